// File: rtl/pwm_mode_counter.sv
// pwm_mode_counter: PWM timebase counter with tick prescaler, programmable
// period and four counting modes (up-wrap, down-reload, up/down triangle,
// one-shot). Drives wrap/done status pulses for downstream compare stages.
//
// Ports:
//   clk      - clock, all logic on rising edge
//   rst      - asynchronous active-high reset
//   en_i     - counter enable; low ignores ticks and holds all state
//   tick_i   - single-cycle tick strobe
//   presc_i  - prescaler: one step every presc_i+1 qualified ticks
//   mode_i   - 00 UP, 01 DOWN, 10 UPDOWN, 11 ONESHOT
//   period_i - terminal count (inclusive)
//   clear_i  - synchronous restart (beats any tick in the same cycle)
//   count_o  - full counter value
//   value_o  - top HIGH_WIDTH bits of the count
//   dir_o    - 0 counting up, 1 counting down
//   wrap_o   - one-cycle pulse on wrap / reload / turnaround at 0
//   done_o   - ONESHOT terminal reached (sticky level)
module pwm_mode_counter #(
  parameter int unsigned WIDTH       = 20,
  parameter int unsigned HIGH_WIDTH  = 8,
  parameter int unsigned PRESC_WIDTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en_i,
  input  logic                   tick_i,
  input  logic [PRESC_WIDTH-1:0] presc_i,
  input  logic [1:0]             mode_i,
  input  logic [WIDTH-1:0]       period_i,
  input  logic                   clear_i,
  output logic [WIDTH-1:0]       count_o,
  output logic [HIGH_WIDTH-1:0]  value_o,
  output logic                   dir_o,
  output logic                   wrap_o,
  output logic                   done_o
);

  typedef enum logic [1:0] {
    MODE_UP      = 2'b00,
    MODE_DOWN    = 2'b01,
    MODE_UPDOWN  = 2'b10,
    MODE_ONESHOT = 2'b11
  } mode_t;

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  mode_t                  mode;
  logic [WIDTH-1:0]       count_q;
  logic [PRESC_WIDTH-1:0] presc_q;
  logic                   dir_q;
  logic                   wrap_q;
  logic                   done_q;

  logic [WIDTH-1:0]       step_count;
  logic                   step_dir;
  logic                   step_wrap;
  logic                   step_done;
  logic                   at_top;
  logic                   at_zero;

  assign mode    = mode_t'(mode_i);
  assign at_top  = (count_q >= period_i);
  assign at_zero = (count_q == '0);

  // Next state if a step happens this cycle; mode and period are used live.
  always_comb begin
    step_count = count_q;
    step_dir   = dir_q;
    step_wrap  = 1'b0;
    step_done  = done_q;
    unique case (mode)
      MODE_UP: begin
        step_dir = 1'b0;
        if (at_top) begin
          step_count = '0;
          step_wrap  = 1'b1;
        end else begin
          step_count = count_q + ONE;
        end
      end
      MODE_DOWN: begin
        step_dir = 1'b1;
        if (at_zero) begin
          step_count = period_i;
          step_wrap  = 1'b1;
        end else begin
          step_count = count_q - ONE;
        end
      end
      MODE_UPDOWN: begin
        if (!dir_q) begin
          if (at_top) begin
            step_dir = 1'b1;
            // At top while sitting at 0 only happens with period 0:
            // the count pins at 0 and every step reports a wrap.
            if (at_zero) step_wrap  = 1'b1;
            else         step_count = count_q - ONE;
          end else begin
            step_count = count_q + ONE;
          end
        end else begin
          if (at_zero) begin
            step_dir   = 1'b0;
            step_wrap  = 1'b1;
            step_count = (period_i == '0) ? '0 : ONE;
          end else begin
            step_count = count_q - ONE;
          end
        end
      end
      MODE_ONESHOT: begin
        step_dir = 1'b0;
        if (at_top) step_done  = 1'b1;
        else        step_count = count_q + ONE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      presc_q <= '0;
      dir_q   <= 1'b0;
      wrap_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      wrap_q <= 1'b0;
      if (clear_i) begin
        presc_q <= '0;
        dir_q   <= 1'b0;
        done_q  <= 1'b0;
        count_q <= (mode == MODE_DOWN) ? period_i : '0;
      end else if (tick_i && en_i) begin
        // >= rather than == so a prescaler left above a lowered presc_i
        // steps on the next qualified tick instead of running to rollover.
        if (presc_q >= presc_i) begin
          presc_q <= '0;
          count_q <= step_count;
          dir_q   <= step_dir;
          wrap_q  <= step_wrap;
          done_q  <= step_done;
        end else begin
          presc_q <= presc_q + PRESC_WIDTH'(1);
        end
      end
    end
  end

  assign count_o = count_q;
  assign value_o = count_q[WIDTH-1 -: HIGH_WIDTH];
  assign dir_o   = dir_q;
  assign wrap_o  = wrap_q;
  assign done_o  = done_q;

endmodule

// File: tb/tb_pwm_mode_counter.sv
// tb_pwm_mode_counter: drives an 8-bit and a default 20-bit pwm_mode_counter
// with shared control inputs and separate periods, compares every output each
// cycle against a behavioural model, plus fixed expected sequences.
module tb_pwm_mode_counter;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        tick;
  logic        clear;
  logic [3:0]  presc;
  logic [1:0]  mode;
  logic [7:0]  period_a;
  logic [19:0] period_b;

  logic [7:0]  count_a;
  logic [3:0]  value_a;
  logic        dir_a, wrap_a, done_a;
  logic [19:0] count_b;
  logic [7:0]  value_b;
  logic        dir_b, wrap_b, done_b;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state, index 0 = 8-bit instance, 1 = 20-bit instance.
  int unsigned m_count [2];
  int unsigned m_presc [2];
  bit          m_dir   [2];
  bit          m_wrap  [2];
  bit          m_done  [2];

  always #5 clk = ~clk;

  pwm_mode_counter #(.WIDTH(8), .HIGH_WIDTH(4), .PRESC_WIDTH(4)) dut_a (
    .clk(clk), .rst(rst), .en_i(en), .tick_i(tick), .presc_i(presc),
    .mode_i(mode), .period_i(period_a), .clear_i(clear),
    .count_o(count_a), .value_o(value_a), .dir_o(dir_a),
    .wrap_o(wrap_a), .done_o(done_a)
  );

  pwm_mode_counter dut_b (
    .clk(clk), .rst(rst), .en_i(en), .tick_i(tick), .presc_i(presc),
    .mode_i(mode), .period_i(period_b), .clear_i(clear),
    .count_o(count_b), .value_o(value_b), .dir_o(dir_b),
    .wrap_o(wrap_b), .done_o(done_b)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  function automatic int unsigned per(input int d);
    return (d == 0) ? int'(period_a) : int'(period_b);
  endfunction

  function automatic void model_reset();
    for (int d = 0; d < 2; d++) begin
      m_count[d] = 0; m_presc[d] = 0; m_dir[d] = 0; m_wrap[d] = 0; m_done[d] = 0;
    end
  endfunction

  // One counting step following the mode rules with plain integer arithmetic.
  function automatic void model_step(input int d);
    int unsigned p = per(d);
    int unsigned c = m_count[d];
    case (mode)
      2'b00: begin
        m_dir[d] = 0;
        if (c >= p) begin c = 0; m_wrap[d] = 1; end else c = c + 1;
      end
      2'b01: begin
        m_dir[d] = 1;
        if (c == 0) begin c = p; m_wrap[d] = 1; end else c = c - 1;
      end
      2'b10: begin
        if (!m_dir[d]) begin
          if (c >= p) begin
            m_dir[d] = 1;
            if (c == 0) m_wrap[d] = 1; else c = c - 1;
          end else c = c + 1;
        end else if (c == 0) begin
          m_dir[d] = 0; m_wrap[d] = 1; c = (p == 0) ? 0 : 1;
        end else c = c - 1;
      end
      default: begin
        m_dir[d] = 0;
        if (c >= p) m_done[d] = 1; else c = c + 1;
      end
    endcase
    m_count[d] = c;
  endfunction

  function automatic void model_clock();
    for (int d = 0; d < 2; d++) begin
      m_wrap[d] = 0;
      if (clear) begin
        m_presc[d] = 0; m_dir[d] = 0; m_done[d] = 0;
        m_count[d] = (mode == 2'b01) ? per(d) : 0;
      end else if (tick && en) begin
        if (m_presc[d] >= int'(presc)) begin
          m_presc[d] = 0;
          model_step(d);
        end else m_presc[d] = m_presc[d] + 1;
      end
    end
  endfunction

  task automatic check_all();
    check("count8", count_a, m_count[0]);
    check("value8", value_a, m_count[0] >> 4);
    check("dir8",   dir_a,   m_dir[0]);
    check("wrap8",  wrap_a,  m_wrap[0]);
    check("done8",  done_a,  m_done[0]);
    check("count20", count_b, m_count[1]);
    check("value20", value_b, m_count[1] >> 12);
    check("dir20",   dir_b,   m_dir[1]);
    check("wrap20",  wrap_b,  m_wrap[1]);
    check("done20",  done_b,  m_done[1]);
  endtask

  // Inputs change 1 ns after the rising edge; outputs sampled at the same point.
  task automatic cycle(input bit t, input bit e, input bit c);
    tick = t; en = e; clear = c;
    @(posedge clk); #1;
    model_clock();
    check_all();
  endtask

  task automatic async_reset();
    rst = 1'b1;
    #2;
    model_reset();
    check_all();
    @(posedge clk); #1;
    rst = 1'b0;
    check_all();
  endtask

  initial begin
    int unsigned ud_cnt [8] = '{1, 2, 3, 2, 1, 0, 1, 2};
    bit          ud_dir [8] = '{0, 0, 0, 1, 1, 1, 0, 0};
    int unsigned dn_cnt [4] = '{2, 1, 0, 2};

    rst = 1'b1; en = 1'b0; tick = 1'b0; clear = 1'b0;
    presc = '0; mode = 2'b00; period_a = 8'd5; period_b = 20'd5;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    rst = 1'b0;

    // UP, period 5, tick every cycle
    cycle(0, 1, 1);
    for (int i = 0; i < 14; i++) begin
      cycle(1, 1, 0);
      check("up_seq",  count_a, (i + 1) % 6);
      check("up_wrap", wrap_a,  ((i + 1) % 6) == 0);
    end

    // prescaler 2 with enable gaps, then asynchronous reset mid-run
    presc = 4'd2;
    cycle(0, 1, 1);
    for (int i = 0; i < 20; i++) cycle(1, (i % 4) != 3, 0);
    async_reset();

    // UPDOWN, period 3
    presc = '0; mode = 2'b10; period_a = 8'd3; period_b = 20'd3;
    cycle(0, 1, 1);
    for (int i = 0; i < 8; i++) begin
      cycle(1, 1, 0);
      check("ud_seq",  count_a, ud_cnt[i]);
      check("ud_dir",  dir_a,   ud_dir[i]);
      check("ud_wrap", wrap_a,  i == 6);
    end
    period_a = 8'd0;
    cycle(0, 1, 1);
    for (int i = 0; i < 4; i++) begin
      cycle(1, 1, 0);
      check("ud0_cnt",  count_a, 0);
      check("ud0_wrap", wrap_a,  1);
    end

    // DOWN, period 4 then lowered to 2 while count is 3
    mode = 2'b01; period_a = 8'd4;
    cycle(0, 1, 1);
    check("dn_load", count_a, 4);
    cycle(1, 1, 0);
    check("dn_first", count_a, 3);
    period_a = 8'd2;
    for (int i = 0; i < 4; i++) begin
      cycle(1, 1, 0);
      check("dn_seq",  count_a, dn_cnt[i]);
      check("dn_wrap", wrap_a,  i == 3);
    end

    // ONESHOT, period 3, then clear together with a tick
    mode = 2'b11; period_a = 8'd3;
    cycle(0, 1, 1);
    for (int i = 0; i < 6; i++) cycle(1, 1, 0);
    check("os_hold", count_a, 3);
    check("os_done", done_a,  1);
    check("os_wrap", wrap_a,  0);
    cycle(1, 1, 1);
    check("os_clr_cnt",  count_a, 0);
    check("os_clr_done", done_a,  0);

    // UP at 10, period lowered to 4
    mode = 2'b00; period_a = 8'd15;
    cycle(0, 1, 1);
    for (int i = 0; i < 10; i++) cycle(1, 1, 0);
    check("up10", count_a, 10);
    period_a = 8'd4;
    cycle(1, 1, 0);
    check("lower_cnt",  count_a, 0);
    check("lower_wrap", wrap_a,  1);

    // 20-bit full-range wrap, reaching the top via DOWN then switching to UP
    mode = 2'b01; period_b = 20'hFFFFF;
    cycle(0, 1, 1);
    check("w20_load",  count_b, 20'hFFFFF);
    check("w20_value", value_b, 8'hFF);
    cycle(1, 1, 0);
    mode = 2'b00;
    cycle(1, 1, 0);
    check("w20_top", count_b, 20'hFFFFF);
    check("w20_dir", dir_b,   0);
    cycle(1, 1, 0);
    check("w20_wrap_cnt", count_b, 0);
    check("w20_wrap",     wrap_b,  1);

    // randomized run
    period_b = 20'd7;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 15) == 0) mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 20) == 0) period_a = 8'($urandom_range(0, 12));
      if ($urandom_range(0, 20) == 0) period_b = 20'($urandom_range(0, 12));
      if ($urandom_range(0, 30) == 0) presc = 4'($urandom_range(0, 3));
      if ($urandom_range(0, 400) == 0) async_reset();
      else cycle($urandom_range(0, 3) != 0, $urandom_range(0, 6) != 0,
                 $urandom_range(0, 39) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
